// File: rtl/angle_bcd_converter.sv
// angle_bcd_converter: scales a raw encoder count to output units
// (FULL_SCALE per COUNTS_PER_REV) and emits the result as packed BCD.
// A product, a restoring shift-subtract divide and an iterative double
// dabble are sequenced one bit per cycle, so no wide combinational
// divider or multiplier chain is built beyond one constant multiply.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  angle handshake (in_ready only while idle)
//   angle [IN_W]         unsigned raw count, captured on accept
//   out_valid/out_ready  result handshake (out_valid only when done)
//   bcd [4*DIGITS]       packed BCD, most significant digit on top
//   overflow             result above 10^DIGITS-1, bcd forced to all 9s
//
// Build option: define ANGLE_BCD_ROUND_EN for round-half-up instead of
// truncation; latency is identical either way.
module angle_bcd_converter #(
   parameter int IN_W           = 12,
   parameter int COUNTS_PER_REV = 1006,
   parameter int FULL_SCALE     = 360,
   parameter int DIGITS         = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       angle,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int S_W    = $clog2(FULL_SCALE + 1);
   localparam int PROD_W = IN_W + S_W + 1;
   localparam int Q_W    = PROD_W;
   localparam int BW     = 4 * DIGITS;
   // remainder stays below the divisor; one extra bit holds the shifted value
   localparam int R_W    = $clog2(COUNTS_PER_REV) + 1;
   localparam int C_W    = $clog2(PROD_W + 1);

   localparam logic [PROD_W-1:0] SCALE   = PROD_W'(FULL_SCALE);
   localparam logic [R_W:0]      DIVISOR = (R_W + 1)'(COUNTS_PER_REV);
   localparam logic [Q_W-1:0]    MAX_Q   = Q_W'(10 ** DIGITS - 1);
   localparam logic [C_W-1:0]    NBITS   = C_W'(PROD_W);
   localparam logic [C_W-1:0]    ONE     = C_W'(1);
`ifdef ANGLE_BCD_ROUND_EN
   localparam logic [PROD_W-1:0] BIAS    = PROD_W'(COUNTS_PER_REV / 2);
`else
   localparam logic [PROD_W-1:0] BIAS    = '0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      DAB,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic [IN_W-1:0]   angle_q;
   logic [PROD_W-1:0] work;
   logic [R_W-1:0]    rem;
   logic [C_W-1:0]    cnt;
   logic [BW-1:0]     dab;
   logic              ovf_q;
   logic [BW-1:0]     bcd_q;
   logic              ovf_out;
   logic              valid_q;

   logic              accept;
   logic              last;
   logic [R_W:0]      rem_sh;
   logic              sub_ok;
   logic [R_W-1:0]    rem_nx;
   logic [PROD_W-1:0] q_nx;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     dab_nx;

   assign accept    = in_valid && in_ready;
   assign last      = (cnt == ONE);
   assign out_valid = valid_q;
   assign bcd       = bcd_q;
   assign overflow  = ovf_out;

   // restoring divide step: work holds remaining dividend bits on top
   // and collects quotient bits from the bottom
   always_comb begin
      rem_sh = {rem, work[PROD_W-1]};
      sub_ok = (rem_sh >= DIVISOR);
      rem_nx = sub_ok ? R_W'(rem_sh - DIVISOR) : R_W'(rem_sh);
      q_nx   = {work[PROD_W-2:0], sub_ok};
   end

   // double dabble step: correct digits >= 5, then shift in next bit
   always_comb begin
      adj = dab;
      for (int i = 0; i < DIGITS; i++) begin
         if (dab[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = dab[4*i +: 4] + 4'd3;
         end
      end
      dab_nx = {adj[BW-2:0], work[Q_W-1]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = MUL;
         end
         MUL: state_nx = DIV;
         DIV: if (last) state_nx = DAB;
         DAB: if (last) state_nx = DONE;
         DONE: if (valid_q && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         angle_q <= '0;
         work    <= '0;
         rem     <= '0;
         cnt     <= '0;
         dab     <= '0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_out <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) angle_q <= angle;
            end
            MUL: begin
               work <= PROD_W'(angle_q) * SCALE + BIAS;
               rem  <= '0;
               cnt  <= NBITS;
            end
            DIV: begin
               work <= q_nx;
               rem  <= rem_nx;
               if (last) begin
                  cnt   <= NBITS;
                  ovf_q <= (q_nx > MAX_Q);
                  dab   <= '0;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            DAB: begin
               dab  <= dab_nx;
               work <= {work[PROD_W-2:0], 1'b0};
               cnt  <= cnt - ONE;
            end
            DONE: begin
               // first DONE cycle publishes the result; it then holds
               if (!valid_q) begin
                  bcd_q   <= ovf_q ? {DIGITS{4'h9}} : dab;
                  ovf_out <= ovf_q;
                  valid_q <= 1'b1;
               end else if (out_ready) begin
                  valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_angle_bcd_converter.sv
// Directed bench for angle_bcd_converter: vector table for the default
// build plus hand sequences for backpressure, reset abort and DIGITS=4.
module tb_angle_bcd_converter;

   localparam int LAT0 = 2 * (12 + $clog2(360 + 1) + 1) + 2;
   localparam int LAT1 = 2 * (12 + $clog2(3600 + 1) + 1) + 2;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] angle;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] bcd;
   logic        overflow;

   logic        in_valid1;
   logic        in_ready1;
   logic [11:0] angle1;
   logic        out_valid1;
   logic        out_ready1;
   logic [15:0] bcd1;
   logic        overflow1;

   int checks;
   int failures;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        ov;
   } vec_t;

   vec_t vecs[10];

   angle_bcd_converter dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .angle     (angle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd),
      .overflow  (overflow)
   );

   angle_bcd_converter #(
      .IN_W           (12),
      .COUNTS_PER_REV (1006),
      .FULL_SCALE     (3600),
      .DIGITS         (4)
   ) dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .angle     (angle1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .bcd       (bcd1),
      .overflow  (overflow1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // counts edges from the accept edge until out_valid; 0 on timeout
   task automatic wait_out(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         if (k == 0) begin
            @(posedge clk);
            #1;
            if (out_valid) k = i;
         end
      end
   endtask

   task automatic convert(input logic [11:0] a, output int k,
                          output logic [11:0] b, output logic ov);
      @(negedge clk);
      angle    = a;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      angle    = 12'hABC;
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      wait_out(k);
      b  = bcd;
      ov = overflow;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          k;
      int          bad;
      logic [11:0] b;
      logic        ov;

      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      angle      = '0;
      out_ready  = 1'b1;
      in_valid1  = 1'b0;
      angle1     = '0;
      out_ready1 = 1'b1;

`ifdef ANGLE_BCD_ROUND_EN
      vecs[0] = '{12'd503,  12'h180, 1'b0};
      vecs[1] = '{12'd1005, 12'h360, 1'b0};
      vecs[2] = '{12'd0,    12'h000, 1'b0};
      vecs[3] = '{12'd4095, 12'h999, 1'b1};
      vecs[4] = '{12'd1006, 12'h360, 1'b0};
      vecs[5] = '{12'd251,  12'h090, 1'b0};
      vecs[6] = '{12'd1,    12'h000, 1'b0};
      vecs[7] = '{12'd2012, 12'h720, 1'b0};
      vecs[8] = '{12'd2794, 12'h999, 1'b1};
      vecs[9] = '{12'd2795, 12'h999, 1'b1};
`else
      vecs[0] = '{12'd503,  12'h180, 1'b0};
      vecs[1] = '{12'd1005, 12'h359, 1'b0};
      vecs[2] = '{12'd0,    12'h000, 1'b0};
      vecs[3] = '{12'd4095, 12'h999, 1'b1};
      vecs[4] = '{12'd1006, 12'h360, 1'b0};
      vecs[5] = '{12'd251,  12'h089, 1'b0};
      vecs[6] = '{12'd1,    12'h000, 1'b0};
      vecs[7] = '{12'd2012, 12'h720, 1'b0};
      vecs[8] = '{12'd2794, 12'h999, 1'b0};
      vecs[9] = '{12'd2795, 12'h999, 1'b1};
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         convert(vecs[i].a, k, b, ov);
         chk($sformatf("lat_%0d", vecs[i].a), 32'(k), 32'(LAT0));
         chk($sformatf("bcd_%0d", vecs[i].a), 32'(b), 32'(vecs[i].b));
         chk($sformatf("ovf_%0d", vecs[i].a), 32'(ov), 32'(vecs[i].ov));
         chk("post_hs_valid", 32'(out_valid), 32'd0);
      end

      // backpressure: result must hold, no accept while busy in DONE
      out_ready = 1'b0;
      @(negedge clk);
      angle    = 12'd503;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(k);
      chk("bp_lat", 32'(k), 32'(LAT0));
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             bcd !== 12'h180 || overflow !== 1'b0) bad++;
         angle    = 12'($urandom);
         in_valid = 1'b1;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      angle     = 12'd28;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hs_valid", 32'(out_valid), 32'd0);
      chk("bp_hs_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_accept", 32'(in_ready), 32'd0);
      wait_out(k);
      chk("bp_next_lat", 32'(k), 32'(LAT0));
      chk("bp_next_bcd", 32'(bcd), 32'h010);
      @(posedge clk);
      #1;

      // reset in the middle of the divide aborts the conversion
      @(negedge clk);
      angle    = 12'd4095;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      chk("abort_no_stale", 32'(bad), 32'd0);
      convert(12'd251, k, b, ov);
      chk("abort_lat", 32'(k), 32'(LAT0));
`ifdef ANGLE_BCD_ROUND_EN
      chk("abort_bcd_251", 32'(b), 32'h090);
`else
      chk("abort_bcd_251", 32'(b), 32'h089);
`endif
      chk("abort_ovf_251", 32'(ov), 32'd0);

      // four-digit build, 3600 units per revolution
      @(negedge clk);
      angle1    = 12'd1005;
      in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         if (k == 0) begin
            @(posedge clk);
            #1;
            if (out_valid1) k = i;
         end
      end
      chk("d4_lat", 32'(k), 32'(LAT1));
      chk("d4_bcd", 32'(bcd1), 32'h3596);
      chk("d4_ovf", 32'(overflow1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
